// File: rtl/digit_glyph_sequencer.sv
// Maps VGA pixel coordinates onto an NDIG-digit decimal readout. The binary value is
// converted to BCD by a serial double-dabble FSM, and the new digits are committed during blanking.
module digit_glyph_sequencer #(
    parameter int         NDIG     = 4,
    parameter logic [9:0] X0       = 10'd64,
    parameter logic [9:0] Y0       = 10'd64,
    parameter int         SCALE_SH = 2,
    parameter logic [5:0] FG_COLOR = 6'b111111,
    parameter logic [5:0] BG_COLOR = 6'b000000,
    parameter bit         LZB      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_start,
    input  logic [13:0] value_in,
    input  logic        value_valid,
    output logic [3:0]  glyph_sel,
    output logic [4:0]  glyph_row,
    output logic [4:0]  glyph_col,
    input  logic [5:0]  rom_data,
    output logic [5:0]  pixel_out,
    output logic        busy
);
    localparam int          CELL   = 8 << SCALE_SH;
    localparam logic [10:0] X_END  = 11'(X0) + 11'(NDIG * CELL);
    localparam logic [10:0] Y_END  = 11'(Y0) + 11'(CELL);
    localparam logic [1:0]  LAST   = 2'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t          state;
    logic [13:0]     pending;
    logic            upd;
    logic [29:0]     sr;
    logic [3:0]      cnt;
    logic [3:0][3:0] disp;   // disp[0] = ones digit

    // One double-dabble step: BCD field sits in sr[29:14], binary in sr[13:0].
    function automatic logic [29:0] dd_step(input logic [29:0] s);
        logic [29:0] t;
        t = s;
        for (int i = 0; i < 4; i++)
            if (t[14+4*i +: 4] >= 4'd5)
                t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
        return t << 1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            upd     <= 1'b0;
            sr      <= '0;
            cnt     <= '0;
            disp    <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (frame_start && upd) begin
                    sr    <= {16'b0, pending};
                    upd   <= 1'b0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= CONVERT;
                end
                CONVERT: begin
                    sr  <= dd_step(sr);
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd13) state <= COMMIT;
                end
                COMMIT: begin
                    disp  <= sr[29:14];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Placed after the FSM so a same-cycle capture survives the upd clear.
            if (value_valid) begin
                pending <= (value_in > 14'd9999) ? 14'd9999 : value_in;
                upd     <= 1'b1;
            end
        end
    end

    // Stage 1: coordinate decode
    logic       in_field, blank;
    logic [1:0] slot;
    logic [2:0] col_c, row_c;
    logic [3:0] digit_c;
    logic [3:0] lz;

    assign in_field = (x >= X0) && ({1'b0, x} < X_END) && (y >= Y0) && ({1'b0, y} < Y_END);
    assign slot     = 2'((x - X0) >> (3 + SCALE_SH));
    assign col_c    = 3'((x - X0) >> SCALE_SH);
    assign row_c    = 3'((y - Y0) >> SCALE_SH);
    assign digit_c  = disp[LAST - slot];

    // lz[s]: every displayed digit from the leftmost through slot s is zero
    always_comb begin
        logic acc;
        acc = 1'b1;
        lz  = '0;
        for (int s = 0; s < NDIG; s++) begin
            acc   = acc & (disp[NDIG-1-s] == 4'd0);
            lz[s] = acc;
        end
    end

    assign blank = LZB && (slot < LAST) && lz[slot];

    logic in_field_d, blank_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glyph_sel  <= '0;
            glyph_row  <= '0;
            glyph_col  <= '0;
            in_field_d <= 1'b0;
            blank_d    <= 1'b0;
            pixel_out  <= '0;
        end else begin
            in_field_d <= in_field;
            blank_d    <= in_field && blank;
            if (in_field) begin
                glyph_sel <= digit_c;
                glyph_row <= {2'b00, row_c};
                glyph_col <= {2'b00, col_c};
            end else begin
                glyph_sel <= '0;
                glyph_row <= '0;
                glyph_col <= '0;
            end
            // Stage 2: rom_data answers the stage-1 address combinationally
            pixel_out <= (in_field_d && !blank_d && rom_data == 6'd0) ? FG_COLOR : BG_COLOR;
        end
    end
endmodule

// File: tb/tb_digit_glyph_sequencer.sv
// Scoreboarded bench for digit_glyph_sequencer: stimulus queues expected glyph/pixel
// results, and a monitor pops them as each item reaches its pipeline stage.
module tb_digit_glyph_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic        frame_start = 1'b0;
    logic [13:0] value_in = '0;
    logic        value_valid = 1'b0;
    logic [3:0]  glyph_sel;
    logic [4:0]  glyph_row, glyph_col;
    logic [5:0]  rom_data;
    logic [5:0]  pixel_out;
    logic        busy;

    digit_glyph_sequencer dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .frame_start(frame_start),
        .value_in(value_in), .value_valid(value_valid), .glyph_sel(glyph_sel),
        .glyph_row(glyph_row), .glyph_col(glyph_col), .rom_data(rom_data),
        .pixel_out(pixel_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // ROM stand-in: rows 0..3 are stroke, rows 4..7 background
    assign rom_data = (glyph_row[2:0] < 3'd4) ? 6'd0 : 6'h3f;

    typedef struct { string name; logic [3:0] sel; logic [4:0] row; logic [4:0] col; } gexp_t;
    typedef struct { string name; logic [5:0] pix; } pexp_t;
    gexp_t gq[$];
    pexp_t pq[$];

    int checks = 0, passes = 0;
    logic       stim_vld = 1'b0;
    logic [1:0] vp = '0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    endtask

    always @(posedge clk) vp <= {vp[0], stim_vld};

    always @(negedge clk) begin
        if (vp[0]) begin
            if (gq.size() == 0) chk("glyph_queue_underflow", 1, 0);
            else begin
                gexp_t e;
                e = gq.pop_front();
                chk({e.name, "_glyph"}, {18'b0, glyph_sel, glyph_row, glyph_col},
                    {18'b0, e.sel, e.row, e.col});
            end
        end
        if (vp[1]) begin
            if (pq.size() == 0) chk("pixel_queue_underflow", 1, 0);
            else begin
                pexp_t p;
                p = pq.pop_front();
                chk({p.name, "_pixel"}, {26'b0, pixel_out}, {26'b0, p.pix});
            end
        end
    end

    task automatic px(input string n, input int xi, input int yi,
                      input int s, input int r, input int c, input logic [5:0] p);
        gexp_t g;
        pexp_t q;
        @(negedge clk);
        x = 10'(xi); y = 10'(yi); stim_vld = 1'b1;
        g.name = n; g.sel = 4'(s); g.row = 5'(r); g.col = 5'(c);
        q.name = n; q.pix = p;
        gq.push_back(g);
        pq.push_back(q);
    endtask

    task automatic flush();
        @(negedge clk);
        stim_vld = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic val(input int v);
        @(negedge clk);
        value_in = 14'(v); value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic start_fs();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic no_busy(input string nm, input int cyc);
        int seen;
        seen = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (busy !== 1'b0) seen++;
        end
        chk(nm, seen, 0);
    endtask

    localparam logic [5:0] FG = 6'h3f;
    localparam logic [5:0] BG = 6'h00;

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_glyph", {glyph_sel, glyph_row, glyph_col}, 0);
        chk("reset_pixel", pixel_out, 0);
        reset_n = 1'b1;

        px("init_slot3", 160, 64, 0, 0, 0, FG);
        px("init_slot0", 64, 64, 0, 0, 0, BG);
        flush();

        val(1234);
        start_fs();
        wait_done(n);
        chk("busy_cycles_1234", n, 15);
        px("v1234_origin", 64, 64, 1, 0, 0, FG);
        px("v1234_slot1", 96, 69, 2, 1, 0, FG);
        px("left_edge_out", 63, 64, 0, 0, 0, BG);
        px("right_last_col", 191, 64, 4, 0, 7, FG);
        px("right_edge_out", 192, 64, 0, 0, 0, BG);
        px("bottom_row7", 64, 95, 1, 7, 0, BG);
        px("bottom_edge_out", 64, 96, 0, 0, 0, BG);
        px("top_edge_out", 64, 63, 0, 0, 0, BG);
        px("mid_slot2", 140, 80, 3, 4, 3, BG);
        flush();

        val(12000);
        start_fs();
        repeat (2) @(negedge clk);
        val(55);
        chk("busy_during_capture", busy, 1);
        wait_done(n);
        chk("clamp_conv_done", busy, 0);
        px("clamp_9999", 64, 64, 9, 0, 0, FG);
        flush();

        start_fs();
        wait_done(n);
        chk("busy_cycles_55", n, 15);
        px("v55_slot0_blank", 64, 64, 0, 0, 0, BG);
        px("v55_slot2", 128, 64, 5, 0, 0, FG);
        px("v55_slot3", 160, 64, 5, 0, 0, FG);
        flush();

        val(7);
        start_fs();
        wait_done(n);
        px("v7_slot1_blank", 96, 64, 0, 0, 0, BG);
        px("v7_slot3", 160, 64, 7, 0, 0, FG);
        flush();

        start_fs();
        no_busy("fs_no_upd_busy", 20);
        px("fs_no_upd_keep", 160, 64, 7, 0, 0, FG);
        flush();

        @(negedge clk);
        value_in = 14'd42; value_valid = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        value_valid = 1'b0; frame_start = 1'b0;
        no_busy("same_cycle_old_upd", 5);
        start_fs();
        wait_done(n);
        chk("busy_cycles_42", n, 15);
        px("v42_slot2", 128, 64, 4, 0, 0, FG);
        px("v42_slot3", 160, 64, 2, 0, 0, FG);
        flush();

        val(8888);
        start_fs();
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_pixel", pixel_out, FG);
        reset_n = 1'b0;
        #1;
        chk("midconv_reset_busy", busy, 0);
        chk("midconv_reset_glyph", {glyph_sel, glyph_row, glyph_col}, 0);
        chk("midconv_reset_pixel", pixel_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        px("post_reset_slot3", 160, 64, 0, 0, 0, FG);
        px("post_reset_slot0", 64, 64, 0, 0, 0, BG);
        px("post_reset_slot2", 128, 64, 0, 0, 0, BG);
        flush();

        chk("queues_drained", gq.size() + pq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/digit_glyph_sequencer.md
Name: digit_glyph_sequencer

Overview:
Drives the per-digit glyph ROMs so a decimal height reading appears as an NDIG-digit field on the VGA frame.
- Latches the latest sensor value and converts it to BCD with a multi-cycle double-dabble FSM.
- Commits the new digits only at frame start, so the display never tears mid-frame.
- Maps each incoming pixel coordinate to a digit slot and a glyph row/col, and returns the final 6-bit pixel colour through a 2-stage pipeline.
- Sits between the VGA timing generator and the colour output mux. The external glyph ROMs (8x8 cells, 0 = stroke, nonzero = cell background) are muxed by glyph_sel.

Parameters:
NDIG, 4, number of displayed digits (1..4)
X0, 10'd64, left pixel of text field
Y0, 10'd64, top pixel of text field
SCALE_SH, 2, glyph magnification = 2^SCALE_SH (each ROM cell drawn as 4x4 pixels)
FG_COLOR, 6'b111111, colour for glyph stroke (rom_data == 0)
BG_COLOR, 6'b000000, colour outside field and for glyph background
LZB, 1, 1 = blank leading zeros (the least significant digit is always shown)

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
x  in  10  current pixel column from timing generator
y  in  10  current pixel row
frame_start  in  1  one-cycle pulse at start of vertical blank
value_in  in  14  binary height value
value_valid  in  1  one-cycle strobe, value_in valid
glyph_sel  out  4  BCD digit selecting which glyph ROM is muxed onto rom_data
glyph_row  out  5  ROM row address (0..7 used, bits [4:3] = 0)
glyph_col  out  5  ROM col address (0..7 used, bits [4:3] = 0)
rom_data  in  6  combinational ROM output for glyph_sel/row/col
pixel_out  out  6  final colour, 2 cycles after x/y
busy  out  1  conversion in progress

Behaviour:
Reset:
- All outputs 0; display digits 0; pending value 0; update flag 0; FSM in IDLE.
- Reset assertion mid-conversion aborts the conversion. Display digits return to 0.

Capture:
- On value_valid, pending <= min(value_in, 9999) and upd <= 1.
- A later value_valid before commit overwrites pending (last value wins).

FSM (IDLE, CONVERT, COMMIT):
- IDLE -> CONVERT on frame_start && upd. Load shift reg {16'b0, pending}; clear upd; cnt <= 0.
- CONVERT, one double-dabble iteration per cycle:
  - add 3 to each BCD nibble >= 5, then shift left 1.
  - After 14 iterations (cnt == 13) go to COMMIT.
- COMMIT: display digits <= BCD nibbles (one cycle), then IDLE.
- busy = 1 in CONVERT and COMMIT; conversion takes 15 cycles from the frame_start edge.
- frame_start while busy is ignored.
- value_valid while busy sets pending/upd for the next frame and does not disturb the current conversion.
- value_valid and frame_start in the same cycle: the frame_start decision uses the old upd/pending. The new value is held for the next frame.

Pixel pipeline:
- Stage 1 (registered at cycle n+1):
  - dx = x - X0, dy = y - Y0.
  - in_field = (x >= X0) && (x < X0 + NDIG*(8<<SCALE_SH)) && (y >= Y0) && (y < Y0 + (8<<SCALE_SH)). The comparisons are made before the subtraction, so dx/dy underflow is never used.
  - slot = dx >> (3+SCALE_SH), where slot 0 = most significant displayed digit.
  - glyph_col = (dx >> SCALE_SH) & 7; glyph_row = (dy >> SCALE_SH) & 7; glyph_sel = digit[slot].
  - blank = LZB && slot < NDIG-1 && all digits in slots 0..slot are 0.
  - Outside the field, glyph_sel/row/col hold 0.
- Stage 2 (cycle n+2):
  - pixel_out = (in_field_d && !blank_d && rom_data == 0) ? FG_COLOR : BG_COLOR.
- Total latency from x/y to pixel_out is 2 cycles, fixed. The timing generator delays hsync/vsync by 2 to match.
- Display digits change only in COMMIT, which occurs in vertical blank because frame_start marks blanking and 15 cycles << blank period.

Test Plan:
- Reset with reset_n = 0 mid-CONVERT -> busy = 0, pixel_out = 0, glyph_sel/row/col = 0 immediately; after release, the field shows "0" in slot 3 only (LZB = 1).
- value_in = 1234 + value_valid, then frame_start -> busy high 15 cycles; digits 1,2,3,4. At x = X0, y = Y0: glyph_sel = 1, row = 0, col = 0. At x = X0+32, y = Y0+5: glyph_sel = 2, row = 1, col = 0. pixel_out appears 2 cycles after x/y.
- value_in = 12000 -> displayed 9999. value_in = 7 with LZB = 1 -> slots 0..2 output BG_COLOR, slot 3 shows glyph 7.
- value_valid = 55 while busy converting 1234 -> 1234 committed this frame; next frame_start commits 55. frame_start with upd = 0 -> busy stays 0 and digits are unchanged.
- Field edges: x = X0-1 -> BG_COLOR; x = X0+127 (last field column, NDIG = 4) -> in field, col = 7; x = X0+128 -> BG_COLOR. Same for y = Y0+31 (row 7) and y = Y0+32.
- Stroke mapping: rom_data forced to 0 in field -> FG_COLOR; rom_data = 6'b111111 -> BG_COLOR; every pixel during a COMMIT cycle is in blanking (no visible change).
